dmem_responder: RTL

- Data-memory slave serving the pipeline's memory stage: accepts r/w/sel/addr/data requests and returns load data.
- Inserts a configurable number of wait states, signalled on mdelay; the memory stage freezes while mdelay is high.
- Byte-addressed, little-endian, single-port word array.

---
 rtl/dmem_if.sv | 36 +++
 rtl/dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bundle between the memory pipeline stage and dmem_responder.
// The misalign flag exists only when DMEM_MISALIGN_CHECK_EN is defined.
interface dmem_if #(
    parameter int width = 32
);
    logic [width-1:0] addr_to_mem;
    logic [width-1:0] data_to_mem;
    logic             w;
    logic             r;
    logic [1:0]       sel;
    logic [width-1:0] data_from_mem;
    logic             mdelay;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic             misalign;
`endif

`ifdef DMEM_MISALIGN_CHECK_EN
    modport master (
        output addr_to_mem, data_to_mem, w, r, sel,
        input  data_from_mem, mdelay, misalign
    );
    modport slave (
        input  addr_to_mem, data_to_mem, w, r, sel,
        output data_from_mem, mdelay, misalign
    );
`else
    modport master (
        output addr_to_mem, data_to_mem, w, r, sel,
        input  data_from_mem, mdelay
    );
    modport slave (
        input  addr_to_mem, data_to_mem, w, r, sel,
        output data_from_mem, mdelay
    );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Byte-addressed little-endian data memory with LATENCY wait states on mdelay.
// Optional macro DMEM_MISALIGN_CHECK_EN adds misaligned-access detection and suppression.
module dmem_responder #(
    parameter int width   = 32,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    dmem_if.slave    bus
);
    localparam int ADDR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW        = ADDR_BITS + 2;
    localparam int CNT_W     = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam bit HAS_WAIT  = (LATENCY > 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (LATENCY > 0) ? CNT_W'(LATENCY - 1) : {CNT_W{1'b0}};

    localparam logic [1:0] SEL_BYTE = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_WORD = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    addr_q;
    logic [width-1:0] data_q;
    logic [1:0]       sel_q;
    logic             w_q;

    logic             req_s;
    logic             capture_s;
    logic             mdelay_s;
    logic [AW-1:0]    acc_addr_s;
    logic [width-1:0] acc_data_s;
    logic [1:0]       acc_sel_s;
    logic             acc_rd_s;
    logic             acc_wr_s;
    logic             mis_s;
    logic             wr_en_s;
    logic [ADDR_BITS-1:0] idx_s;
    logic [width-1:0] rd_word_s;
    logic [width-1:0] load_s;
    logic [width-1:0] merged_s;

    logic [width-1:0] mem [DEPTH];

    assign req_s = (bus.r | bus.w) && (bus.sel != SEL_NONE);

    // Next-state, wait-counter and capture decode for the wait-state FSM.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_s = 1'b0;
        mdelay_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (HAS_WAIT && req_s) begin
                    capture_s = 1'b1;
                    mdelay_s  = 1'b1;
                    cnt_d     = CNT_LOAD;
                    // LATENCY==1 has no BUSY cycle: the request cycle is the only stall.
                    state_d   = (CNT_LOAD == {CNT_W{1'b0}}) ? ST_DONE : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                mdelay_s = 1'b1;
                if (cnt_q > {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; held stable through BUSY and DONE so live inputs are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= {AW{1'b0}};
            data_q <= {width{1'b0}};
            sel_q  <= 2'b00;
            w_q    <= 1'b0;
        end else if (capture_s) begin
            addr_q <= bus.addr_to_mem[AW-1:0];
            data_q <= bus.data_to_mem;
            sel_q  <= bus.sel;
            w_q    <= bus.w;
        end else begin
            addr_q <= addr_q;
            data_q <= data_q;
            sel_q  <= sel_q;
            w_q    <= w_q;
        end
    end

    // With no wait states the live request is the access; otherwise the captured one in DONE.
    always_comb begin
        if (HAS_WAIT) begin
            acc_addr_s = addr_q;
            acc_data_s = data_q;
            acc_sel_s  = sel_q;
            acc_rd_s   = (state_q == ST_DONE) && !w_q;
            acc_wr_s   = (state_q == ST_DONE) && w_q;
        end else begin
            acc_addr_s = bus.addr_to_mem[AW-1:0];
            acc_data_s = bus.data_to_mem;
            acc_sel_s  = bus.sel;
            acc_rd_s   = req_s && !bus.w;
            acc_wr_s   = req_s && bus.w;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_s = ((acc_sel_s == SEL_HALF) && acc_addr_s[0]) ||
                   ((acc_sel_s == SEL_WORD) && (acc_addr_s[1:0] != 2'b00));
    assign bus.misalign = rst_n && (acc_rd_s || acc_wr_s) && mis_s;
`else
    assign mis_s = 1'b0;
`endif

    // Higher address bits are dropped so the word index wraps modulo DEPTH.
    assign idx_s     = acc_addr_s[ADDR_BITS+1:2];
    assign rd_word_s = mem[idx_s];
    assign wr_en_s   = rst_n && acc_wr_s && !mis_s;

    // Lane extraction for loads; sub-word results are zero-extended and right-aligned.
    always_comb begin
        load_s = {width{1'b0}};
        case (acc_sel_s)
            SEL_BYTE: load_s = {{(width-8){1'b0}},  rd_word_s[{acc_addr_s[1:0], 3'b000} +: 8]};
            SEL_HALF: load_s = {{(width-16){1'b0}}, rd_word_s[{acc_addr_s[1], 4'b0000} +: 16]};
            SEL_WORD: load_s = rd_word_s;
            default:  load_s = {width{1'b0}};
        endcase
    end

    // Read-modify-write merge so byte and half stores touch only their lane.
    always_comb begin
        merged_s = rd_word_s;
        case (acc_sel_s)
            SEL_BYTE: merged_s[{acc_addr_s[1:0], 3'b000} +: 8] = acc_data_s[7:0];
            SEL_HALF: merged_s[{acc_addr_s[1], 4'b0000} +: 16] = acc_data_s[15:0];
            SEL_WORD: merged_s = acc_data_s;
            default:  merged_s = rd_word_s;
        endcase
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[idx_s] <= merged_s;
        end
    end

    assign bus.mdelay        = rst_n && mdelay_s;
    assign bus.data_from_mem = (rst_n && acc_rd_s && !mis_s) ? load_s : {width{1'b0}};

endmodule
